// File: rtl/gcd_feeder.sv
// Operand-pair FIFO feeding an external GCD core through a load/run handshake,
// with a per-pair run-cycle timeout and an in-order result holding register.
module gcd_feeder #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         core_start,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  input  logic         core_done,
  input  logic [W-1:0] core_r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_r,
  output logic         out_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   FULL_C = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  state_t        r_state;
  logic [W-1:0]  r_mem_a [DEPTH];
  logic [W-1:0]  r_mem_b [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [CW-1:0] r_run_cnt;
  logic          r_core_start;
  logic [W-1:0]  r_core_a;
  logic [W-1:0]  r_core_b;
  logic          r_out_valid;
  logic [W-1:0]  r_out_a;
  logic [W-1:0]  r_out_b;
  logic [W-1:0]  r_out_r;
  logic          r_out_err;

  logic w_push;
  logic w_pop;

  assign in_ready   = (r_count < FULL_C);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign core_start = r_core_start;
  assign core_a     = r_core_a;
  assign core_b     = r_core_b;
  assign out_valid  = r_out_valid;
  assign out_a      = r_out_a;
  assign out_b      = r_out_b;
  assign out_r      = r_out_r;
  assign out_err    = r_out_err;

  // FIFO storage: data only, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= in_a;
      r_mem_b[r_wptr] <= in_b;
    end
  end

  // FIFO pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer: pop -> load -> run -> hold; core_done outranks the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_run_cnt    <= '0;
      r_core_start <= 1'b0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_out_valid  <= 1'b0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_out_r      <= '0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_core_a  <= r_mem_a[r_rptr];
            r_core_b  <= r_mem_b[r_rptr];
            r_run_cnt <= '0;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_core_start <= 1'b1;
          r_state      <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            r_out_a      <= r_core_a;
            r_out_b      <= r_core_b;
            r_out_r      <= core_r;
            r_out_err    <= 1'b0;
            r_out_valid  <= 1'b1;
            r_core_start <= 1'b0;
            r_state      <= S_HOLD;
          end else if (r_run_cnt == LAST_C) begin
            r_out_a      <= r_core_a;
            r_out_b      <= r_core_b;
            r_out_r      <= '0;
            r_out_err    <= 1'b1;
            r_out_valid  <= 1'b1;
            r_core_start <= 1'b0;
            r_state      <= S_HOLD;
          end else begin
            r_run_cnt <= r_run_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder with a behavioural GCD core stub whose
// completion timing is selectable per test.
module tb_gcd_feeder;
  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         core_start;
  logic [W-1:0] core_a, core_b;
  logic         core_done;
  logic [W-1:0] core_r;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a, out_b, out_r;
  logic         out_err;

  int checks   = 0;
  int failures = 0;

  // 0: done on every RUN cycle, 1: never done, 2: done held high always,
  // 3: done only on the 8th RUN cycle (coincides with the timeout)
  int       core_mode;
  logic [7:0] rc;

  always #5 clk = ~clk;

  gcd_feeder #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_r(core_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_r(out_r), .out_err(out_err)
  );

  function automatic logic [W-1:0] stub_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  always @(posedge clk) rc <= core_start ? rc + 8'd1 : 8'd0;

  assign core_r    = stub_gcd(core_a, core_b);
  assign core_done = (core_mode == 0) ? core_start :
                     (core_mode == 2) ? 1'b1 :
                     (core_mode == 3) ? (core_start && rc == 8'd7) : 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] pa [6] = '{16'd48, 16'd7, 16'd0, 16'd17, 16'd35, 16'd100};
  logic [W-1:0] pb [6] = '{16'd18, 16'd0, 16'd7, 16'd5,  16'd21, 16'd75};
  logic [W-1:0] pr [6] = '{16'd6,  16'd7, 16'd7, 16'd1,  16'd7,  16'd25};

  initial begin
    int idx, pulses, starts, found;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; core_mode = 0;
    repeat (3) tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;
    tick;

    // Single pair, core_done held high everywhere: only the RUN sample counts
    core_mode = 2; out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'd12; in_b = 16'd18;
    tick;
    in_valid = 1'b0;
    chk("t1_c1_valid", out_valid, 0);
    tick;
    chk("t1_load_start", core_start, 0);
    chk("t1_load_a", core_a, 12);
    chk("t1_load_b", core_b, 18);
    chk("t1_c2_valid", out_valid, 0);
    tick;
    chk("t1_run_start", core_start, 1);
    chk("t1_c3_valid", out_valid, 0);
    tick;
    chk("t1_c4_valid", out_valid, 1);
    chk("t1_out_a", out_a, 12);
    chk("t1_out_b", out_b, 18);
    chk("t1_out_r", out_r, 6);
    chk("t1_out_err", out_err, 0);
    chk("t1_start_drop", core_start, 0);
    tick;
    chk("t1_c5_valid", out_valid, 0);
    core_mode = 0;
    tick;

    // Back-to-back pushes with downstream stalled, then fill past a pop
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
      tick;
    end
    in_a = pa[5]; in_b = pb[5];
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_r", out_r, 6);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("hold_valid", out_valid, 1);
      chk("hold_r", out_r, 6);
      chk("hold_a", out_a, 48);
      chk("hold_b", out_b, 18);
      chk("hold_start", core_start, 0);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick;
    chk("rel_valid", out_valid, 0);
    chk("rel_ready_still_full", in_ready, 0);
    tick;
    chk("pop_in_ready", in_ready, 1);
    chk("pop_core_a", core_a, 7);
    chk("pop_core_b", core_b, 0);
    chk("pop_start", core_start, 0);
    tick;
    in_valid = 1'b0;
    chk("refill_ready", in_ready, 0);
    idx = 1;
    for (int k = 0; k < 60; k++) begin
      tick;
      if (out_valid) begin
        if (idx < 6) begin
          chk("ord_a", out_a, pa[idx]);
          chk("ord_b", out_b, pb[idx]);
          chk("ord_r", out_r, pr[idx]);
          chk("ord_err", out_err, 0);
        end
        idx++;
      end
    end
    chk("ord_count", idx, 6);

    // Core that never finishes: timeout after exactly TIMEOUT RUN cycles
    core_mode = 1;
    in_valid = 1'b1; in_a = 16'd20; in_b = 16'd8;
    tick;
    in_valid = 1'b0;
    repeat (9) tick;
    chk("to_pre_valid", out_valid, 0);
    chk("to_pre_start", core_start, 1);
    tick;
    chk("to_valid", out_valid, 1);
    chk("to_err", out_err, 1);
    chk("to_r", out_r, 0);
    chk("to_start_drop", core_start, 0);
    tick;
    chk("to_clear", out_valid, 0);
    core_mode = 0;
    in_valid = 1'b1; in_a = 16'd21; in_b = 16'd14;
    tick;
    in_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid && found == 0) begin
        found = 1;
        chk("to_next_r", out_r, 7);
        chk("to_next_err", out_err, 0);
        chk("to_next_a", out_a, 21);
      end
      tick;
    end
    chk("to_next_seen", found, 1);

    // core_done on the same cycle the timeout fires: done must win
    core_mode = 3;
    in_valid = 1'b1; in_a = 16'd30; in_b = 16'd12;
    tick;
    in_valid = 1'b0;
    repeat (9) tick;
    chk("tie_pre_valid", out_valid, 0);
    tick;
    chk("tie_valid", out_valid, 1);
    chk("tie_err", out_err, 0);
    chk("tie_r", out_r, 6);
    tick;

    // Reset during RUN with two pairs queued
    core_mode = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'(5 + i); in_b = 16'(10 + i);
      tick;
    end
    in_valid = 1'b0;
    tick;
    chk("rr_running", core_start, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rr_valid", out_valid, 0);
    chk("rr_start", core_start, 0);
    chk("rr_core_a", core_a, 0);
    chk("rr_core_b", core_b, 0);
    chk("rr_out_a", out_a, 0);
    chk("rr_out_b", out_b, 0);
    chk("rr_out_r", out_r, 0);
    chk("rr_err", out_err, 0);
    chk("rr_in_ready", in_ready, 1);
    core_mode = 0;
    pulses = 0; starts = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (out_valid) pulses++;
      if (core_start) starts++;
    end
    chk("rr_no_result", pulses, 0);
    chk("rr_no_start", starts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
